// File: rtl/fadd_arb_n40_pkg.sv
// fadd_pkg_N40: shared widths, requester ids and tag type for the fsincos adder arbiter.
package fadd_pkg_N40;
    localparam int FRAC_WIDTH_DEF = 40;
    localparam int EXP_WIDTH_DEF  = 8;
    localparam int FLOAT_W        = 1 + EXP_WIDTH_DEF + FRAC_WIDTH_DEF;
    localparam int NUM_REQ        = 2;
    localparam int ID_W           = 1;

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;
endpackage

// File: rtl/fadd_arb_n40_rsp_fifo.sv
// fadd_rsp_fifo: first-word fall-through sync FIFO, depth 2^AW, extra pointer bit for full/empty.
module fadd_rsp_fifo
    import fadd_pkg_N40::*;
#(
    parameter int W  = FLOAT_W,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data
);
    localparam int D  = 1 << AW;
    localparam int PW = AW + 1;

    logic [W-1:0]  mem_q [D];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic          empty, full, do_push, do_pop;

    always_comb begin
        empty   = wr_q == rd_q;
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q + PW'(do_push);
        rd_d    = rd_q + PW'(do_pop);
        valid   = !empty;
        // head is masked while empty so the data port reads zero out of reset
        data    = empty ? '0 : mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/fadd_arb_n40.sv
// fadd_arb_n40: round-robin, credit-gated issue of sin/cos operand pairs to the shared
// fixed-latency adder, with tag tracking and per-requester response FIFOs.
module fadd_arb_n40
    import fadd_pkg_N40::*;
#(
    parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
    parameter int EXP_WIDTH  = EXP_WIDTH_DEF,
    parameter int LATENCY    = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [1:0]                      req_valid,
    output logic [1:0]                      req_ready,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]   req0_op_a,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]   req0_op_b,
    input  logic                            req0_sub,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]   req1_op_a,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]   req1_op_b,
    input  logic                            req1_sub,
    output logic                            fadd_valid,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]   fadd_op_a,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]   fadd_op_b,
    output logic                            fadd_sub,
    input  logic                            fadd_res_valid,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]   fadd_res,
    output logic [1:0]                      rsp_valid,
    input  logic [1:0]                      rsp_ready,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]   rsp0_data,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]   rsp1_data,
    output logic                            err
);
    localparam int W  = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int CW = FIFO_AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(1 << FIFO_AW);

    logic [NUM_REQ-1:0] elig, gnt, pop, push;
    logic [CW-1:0]      cnt_q [NUM_REQ];
    logic [CW-1:0]      cnt_d [NUM_REQ];
    req_id_t            rr_q, rr_d, fadd_id_q, fadd_id_d;
    logic               fadd_valid_q, fadd_valid_d, fadd_sub_q, fadd_sub_d, err_q, err_d;
    logic [W-1:0]       fadd_op_a_q, fadd_op_a_d, fadd_op_b_q, fadd_op_b_d;
    tag_t               tag_q [LATENCY];
    tag_t               tag_d [LATENCY];
    tag_t               tag_out;

    always_comb begin
        // cnt counts in-flight plus queued results, so a grant always has a FIFO slot waiting
        for (int i = 0; i < NUM_REQ; i++) elig[i] = rst_n && req_valid[i] && (cnt_q[i] < DEPTH);
        gnt[0]       = elig[0] && (rr_q[0] || !elig[1]);
        gnt[1]       = elig[1] && (!rr_q[0] || !elig[0]);
        rr_d         = (|gnt) ? req_id_t'(gnt[1]) : rr_q;
        fadd_valid_d = |gnt;
        fadd_id_d    = (|gnt) ? req_id_t'(gnt[1]) : fadd_id_q;
        fadd_op_a_d  = gnt[1] ? req1_op_a : (gnt[0] ? req0_op_a : fadd_op_a_q);
        fadd_op_b_d  = gnt[1] ? req1_op_b : (gnt[0] ? req0_op_b : fadd_op_b_q);
        fadd_sub_d   = gnt[1] ? req1_sub  : (gnt[0] ? req0_sub  : fadd_sub_q);
        tag_d[0]     = '{valid: fadd_valid_q, id: fadd_id_q};
        for (int k = 1; k < LATENCY; k++) tag_d[k] = tag_q[k-1];
        tag_out      = tag_q[LATENCY-1];
        push         = (fadd_res_valid && tag_out.valid) ? (tag_out.id[0] ? 2'b10 : 2'b01) : 2'b00;
        err_d        = err_q || (fadd_res_valid != tag_out.valid);
        pop          = rsp_valid & rsp_ready;
        for (int i = 0; i < NUM_REQ; i++) cnt_d[i] = cnt_q[i] + CW'(gnt[i]) - CW'(pop[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= req_id_t'(1);
            fadd_id_q    <= '0;
            fadd_valid_q <= 1'b0;
            fadd_op_a_q  <= '0;
            fadd_op_b_q  <= '0;
            fadd_sub_q   <= 1'b0;
            err_q        <= 1'b0;
            for (int k = 0; k < LATENCY; k++) tag_q[k] <= '0;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            rr_q         <= rr_d;
            fadd_id_q    <= fadd_id_d;
            fadd_valid_q <= fadd_valid_d;
            fadd_op_a_q  <= fadd_op_a_d;
            fadd_op_b_q  <= fadd_op_b_d;
            fadd_sub_q   <= fadd_sub_d;
            err_q        <= err_d;
            for (int k = 0; k < LATENCY; k++) tag_q[k] <= tag_d[k];
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign req_ready  = gnt;
    assign fadd_valid = fadd_valid_q;
    assign fadd_op_a  = fadd_op_a_q;
    assign fadd_op_b  = fadd_op_b_q;
    assign fadd_sub   = fadd_sub_q;
    assign err        = err_q;

    fadd_rsp_fifo #(.W(W), .AW(FIFO_AW)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push[0]),
        .push_data (fadd_res),
        .pop       (rsp_ready[0]),
        .valid     (rsp_valid[0]),
        .data      (rsp0_data)
    );

    fadd_rsp_fifo #(.W(W), .AW(FIFO_AW)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push[1]),
        .push_data (fadd_res),
        .pop       (rsp_ready[1]),
        .valid     (rsp_valid[1]),
        .data      (rsp1_data)
    );
endmodule

// File: tb/tb_fadd_arb_n40.sv
// tb_fadd_arb_n40: directed and random stimulus checked against a queue-based model of
// issue order, credits and result timing; the adder stub returns op_a after LATENCY cycles.
module tb_fadd_arb_n40;
    localparam int W   = 49;
    localparam int LAT = 4;
    localparam logic [W-1:0] A1 = {1'b0, 8'h7F, 40'h80_0000_0000};

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [W-1:0] req0_op_a = '0, req0_op_b = '0, req1_op_a = '0, req1_op_b = '0;
    logic         req0_sub = 1'b0, req1_sub = 1'b0, inj = 1'b0;
    logic         fadd_valid, fadd_sub, fadd_res_valid, err;
    logic [W-1:0] fadd_op_a, fadd_op_b, fadd_res, rsp0_data, rsp1_data;
    logic [LAT-1:0] sv;
    logic [W-1:0] sd [LAT];

    int   tests = 0, fails = 0, now = 0, base = 0;
    ent_t mq [2][$];
    int   acc [2] = '{0, 0};
    int   pops [2] = '{0, 0};
    int   grants [$];
    logic last = 1'b1, fv_m = 1'b0, fs_m = 1'b0, err_m = 1'b0;
    logic [W-1:0] fa_m = '0, fb_m = '0;

    always #5 clk = ~clk;

    fadd_arb_n40 dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_op_a(req0_op_a), .req0_op_b(req0_op_b), .req0_sub(req0_sub),
        .req1_op_a(req1_op_a), .req1_op_b(req1_op_b), .req1_sub(req1_sub),
        .fadd_valid(fadd_valid), .fadd_op_a(fadd_op_a), .fadd_op_b(fadd_op_b), .fadd_sub(fadd_sub),
        .fadd_res_valid(fadd_res_valid), .fadd_res(fadd_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp0_data(rsp0_data), .rsp1_data(rsp1_data),
        .err(err)
    );

    // adder stub: fixed latency, result = op_a, reset together with the DUT
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv <= '0;
            for (int k = 0; k < LAT; k++) sd[k] <= '0;
        end else begin
            sv    <= {sv[LAT-2:0], fadd_valid};
            sd[0] <= fadd_op_a;
            for (int k = 1; k < LAT; k++) sd[k] <= sd[k-1];
        end
    end
    assign fadd_res_valid = sv[LAT-1] | inj;
    assign fadd_res       = sd[LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rnd_ops();
        req0_op_a = W'({$urandom, $urandom});
        req0_op_b = W'({$urandom, $urandom});
        req1_op_a = W'({$urandom, $urandom});
        req1_op_b = W'({$urandom, $urandom});
        req0_sub  = 1'($urandom);
        req1_sub  = 1'($urandom);
    endtask

    task automatic tick();
        logic [1:0] e, g;
        logic       rv;
        ent_t       n;
        #1;
        for (int i = 0; i < 2; i++) e[i] = req_valid[i] && (mq[i].size() < 4);
        g = (e == 2'b11) ? (last ? 2'b01 : 2'b10) : e;
        chk("req_ready", 64'(req_ready), 64'(g));
        chk("fadd_valid", 64'(fadd_valid), 64'(fv_m));
        chk("fadd_op_a", 64'(fadd_op_a), 64'(fa_m));
        chk("fadd_op_b", 64'(fadd_op_b), 64'(fb_m));
        chk("fadd_sub", 64'(fadd_sub), 64'(fs_m));
        chk("err", 64'(err), 64'(err_m));
        for (int i = 0; i < 2; i++) begin
            rv = (mq[i].size() > 0) && (now >= mq[i][0].c + LAT + 2);
            chk($sformatf("rsp_valid%0d", i), 64'(rsp_valid[i]), 64'(rv));
            if (rv) begin
                chk($sformatf("rsp%0d_data", i), 64'(i == 1 ? rsp1_data : rsp0_data), 64'(mq[i][0].d));
                if (rsp_ready[i]) begin
                    void'(mq[i].pop_front());
                    pops[i]++;
                end
            end
        end
        if (g != 2'b00) begin
            n.d = g[1] ? req1_op_a : req0_op_a;
            n.c = now;
            mq[g[1]].push_back(n);
            acc[g[1]]++;
            grants.push_back(int'(g[1]));
            last = g[1];
            fa_m = g[1] ? req1_op_a : req0_op_a;
            fb_m = g[1] ? req1_op_b : req0_op_b;
            fs_m = g[1] ? req1_sub : req0_sub;
        end
        fv_m  = |g;
        err_m = err_m | inj;
        @(negedge clk);
        now++;
    endtask

    task automatic run(input logic [1:0] v, input logic [1:0] r, input int n);
        for (int j = 0; j < n; j++) begin
            req_valid = v;
            rsp_ready = r;
            rnd_ops();
            tick();
        end
    endtask

    task automatic zero_check(input string pfx);
        chk({pfx, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({pfx, "_fadd_valid"}, 64'(fadd_valid), 64'(0));
        chk({pfx, "_fadd_op_a"}, 64'(fadd_op_a), 64'(0));
        chk({pfx, "_fadd_op_b"}, 64'(fadd_op_b), 64'(0));
        chk({pfx, "_fadd_sub"}, 64'(fadd_sub), 64'(0));
        chk({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({pfx, "_rsp0_data"}, 64'(rsp0_data), 64'(0));
        chk({pfx, "_rsp1_data"}, 64'(rsp1_data), 64'(0));
        chk({pfx, "_err"}, 64'(err), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        req_valid = 2'b11;
        #3;
        zero_check("reset");
        @(negedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b1;

        // contention: grants alternate starting with requester 0
        grants.delete();
        run(2'b11, 2'b11, 6);
        chk("t2_grants", 64'(grants.size()), 64'(6));
        for (int j = 0; j < grants.size(); j++) chk($sformatf("t2_grant%0d", j), 64'(grants[j]), 64'(j % 2));
        run(2'b00, 2'b11, 8);

        // single op: result appears six cycles after the handshake
        base = now;
        req_valid = 2'b01; rsp_ready = 2'b00;
        req0_op_a = A1; req0_op_b = A1; req0_sub = 1'b0;
        tick();
        chk("t1_accepts", 64'(grants[grants.size()-1]), 64'(0));
        run(2'b00, 2'b00, 5);
        #1;
        chk("t1_time", 64'(now - base), 64'(6));
        chk("t1_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        chk("t1_data", 64'(rsp0_data), 64'(A1));
        run(2'b00, 2'b11, 2);

        // credit stall
        base = acc[0];
        run(2'b01, 2'b00, 12);
        chk("t3_accepts", 64'(acc[0] - base), 64'(4));
        run(2'b01, 2'b01, 1);
        run(2'b01, 2'b00, 10);
        chk("t3_after_pop", 64'(acc[0] - base), 64'(5));
        run(2'b00, 2'b11, 10);

        // push and pop of FIFO0 in the same cycle
        run(2'b01, 2'b00, 3);
        run(2'b00, 2'b00, 8);
        run(2'b01, 2'b00, 1);
        run(2'b00, 2'b00, 4);
        run(2'b00, 2'b01, 1);
        run(2'b00, 2'b00, 3);
        base = pops[0];
        run(2'b00, 2'b01, 8);
        chk("t4_drained", 64'(pops[0] - base), 64'(3));

        // random traffic
        for (int j = 0; j < 300; j++) begin
            req_valid = 2'($urandom);
            rsp_ready = 2'($urandom);
            rnd_ops();
            tick();
        end
        run(2'b00, 2'b11, 12);

        // stray result
        inj = 1'b1;
        run(2'b00, 2'b00, 1);
        inj = 1'b0;
        run(2'b00, 2'b00, 4);
        chk("t5_sticky", 64'(err), 64'(1));

        // reset with two ops in flight
        run(2'b11, 2'b00, 2);
        rst_n = 1'b0;
        #1;
        zero_check("midreset");
        for (int i = 0; i < 2; i++) mq[i].delete();
        grants.delete();
        last = 1'b1; fv_m = 1'b0; fs_m = 1'b0; err_m = 1'b0; fa_m = '0; fb_m = '0;
        @(negedge clk);
        @(negedge clk);
        now += 2;
        rst_n = 1'b1;
        run(2'b11, 2'b00, 1);
        chk("t6_first_grant", 64'(grants[0]), 64'(0));
        run(2'b00, 2'b11, 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fadd_arb_n40.md
Name: fadd_arb_N40

Overview:
- Two-requester arbiter and sequencer for the shared 40-bit-fraction floating-point adder datapath (far/close paths) in the fsincos core.
- Accepts operand pairs from the sin and cos evaluation paths over valid/ready handshakes and issues at most one op per cycle to the fixed-latency adder pipeline.
- Tags each op and tracks it through the pipeline, then steers each result into a per-requester response FIFO.
- Issue is credit-gated, so a result always has a FIFO slot when it emerges.

Parameters:
- FRAC_WIDTH, 40, fraction width including hidden bit.
- EXP_WIDTH, 8, exponent width.
- LATENCY, 4, adder pipeline depth in cycles (>=1), issue to result.
- FIFO_AW, 2, log2 of response FIFO depth per requester (depth 4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  operand pair valid; bit i = requester i.
- req_ready  out  2  operand pair accepted this cycle.
- req0_op_a, req0_op_b  in  1+EXP_WIDTH+FRAC_WIDTH each  requester 0 operands, packed {sign,exp,frac}.
- req0_sub  in  1  requester 0: 1 = a-b, 0 = a+b.
- req1_op_a, req1_op_b, req1_sub  in  same widths  requester 1 operands and op select.
- fadd_valid  out  1  issue strobe to adder.
- fadd_op_a, fadd_op_b  out  1+EXP_WIDTH+FRAC_WIDTH each  issued operands.
- fadd_sub  out  1  issued op select.
- fadd_res_valid  in  1  adder result strobe.
- fadd_res  in  1+EXP_WIDTH+FRAC_WIDTH  adder result.
- rsp_valid  out  2  response FIFO i non-empty.
- rsp_ready  in  2  requester i pops its head.
- rsp0_data, rsp1_data  out  1+EXP_WIDTH+FRAC_WIDTH  FIFO head (first-word fall-through).
- err  out  1  sticky protocol error.

Behaviour:
- Reset values: all outputs 0, FIFOs empty, credits 0, tag pipeline invalid, RR pointer = 1, so requester 0 wins first.
- Eligibility: requester i is eligible when req_valid[i] && cnt_i < 2^FIFO_AW.
  - cnt_i = in-flight ops for i + FIFO_i occupancy.
- Grant:
  - Combinational round-robin over eligible requesters, starting after the RR pointer.
  - req_ready = one-hot grant or 0; req_ready may depend on req_valid, but req_valid must not depend on req_ready.
  - On a grant the pointer updates to the winner; with no grant it holds.
- Issue:
  - The granted operands are registered onto fadd_op_a, fadd_op_b and fadd_sub.
  - fadd_valid rises one cycle after the handshake; one issue per cycle maximum; back-to-back issue is allowed.
  - When idle, fadd_valid = 0 and the op buses hold their last value.
- Tag pipeline:
  - A LATENCY-deep shift register of {valid, id} is loaded on fadd_valid.
  - Its output stage aligns with fadd_res_valid exactly LATENCY cycles after fadd_valid.
- Result capture:
  - On fadd_res_valid with the tag output valid, fadd_res is pushed into FIFO[id].
  - A result without a valid tag, or a valid tag without a result, sets err; err clears only on reset. No push occurs in either case.
- Credits:
  - cnt_i += 1 on issue accept (handshake cycle); cnt_i -= 1 on pop (rsp_valid[i] && rsp_ready[i]).
  - A simultaneous accept and pop leaves cnt_i unchanged.
  - cnt_i saturates at 2^FIFO_AW by construction; FIFO overflow is impossible.
- FIFO:
  - rsp_valid[i] = !empty; data = head.
  - Push and pop in the same cycle are legal, including when full (pop frees the slot) and when empty with push (data visible the next cycle, no bypass).
  - Pointers wrap modulo 2^FIFO_AW; one extra bit distinguishes full from empty.
- Ordering: responses per requester are returned in issue order; no ordering between requesters.
- Latency: handshake at cycle t, fadd_valid at t+1, push at t+1+LATENCY, rsp_valid at t+2+LATENCY.
- Reset mid-operation:
  - In-flight tags, FIFOs and credits are all discarded.
  - The adder is reset by the same rst_n; any stray result after reset flags err.

Decomposition:
- Shared package fadd_pkg_N40: FRAC_WIDTH and EXP_WIDTH defaults, packed-float width constant (1+EXP+FRAC), requester-id width, NUM_REQ = 2.
- One sub-module, fadd_rsp_fifo: parameterised-width FWFT sync FIFO (depth 2^FIFO_AW, async active-low reset), instantiated twice.
- The arbiter, credit counters and tag pipeline stay in the top.

Test Plan:
1. Single op.
   - Stimulus: req0 a = {0,8'h7F,40'h80_0000_0000}, b = same, sub = 0; adder stub with LATENCY = 4 returns a.
   - Required response: req_ready = 2'b01 at t, fadd_valid at t+1, rsp_valid[0] at t+6 with data = a; rsp_valid[1] stays 0.
2. Contention.
   - Stimulus: both requesters hold valid for 6 cycles.
   - Required response: grants alternate 0,1,0,1,0,1; the fadd_valid stream is gapless; each FIFO receives 3 results in order.
3. Credit stall.
   - Stimulus: req0 continuously valid, rsp_ready[0] = 0.
   - Required response: exactly 4 accepts, then req_ready[0] = 0. Pulse rsp_ready for 1 cycle and exactly 1 further accept follows.
4. Full FIFO with simultaneous push and pop.
   - Stimulus: FIFO0 holds 3 entries, 1 op in flight, rsp_ready[0] = 1 in the push cycle.
   - Required response: occupancy stays 3, no err, data order preserved.
5. Protocol error.
   - Stimulus: inject fadd_res_valid with no issue.
   - Required response: err = 1 next cycle and sticky; no FIFO push.
6. Reset mid-operation.
   - Stimulus: assert rst_n low with 2 ops in flight.
   - Required response: all outputs 0 asynchronously. After release, rsp_valid = 0 and the first grant goes to requester 0.
